// File: rtl/fir_decim_if.sv
// FIFO-side handshake bundle for fir_decim: input FIFO read port and output FIFO write port.
interface fir_decim_if #(
   parameter int DATA_WIDTH = 32
);
   logic signed [DATA_WIDTH-1:0] din;
   logic                         in_empty;
   logic                         in_rd_en;
   logic signed [DATA_WIDTH-1:0] dout;
   logic                         out_full;
   logic                         out_wr_en;

   modport master (
      output din, in_empty, out_full,
      input  in_rd_en, dout, out_wr_en
   );

   modport slave (
      input  din, in_empty, out_full,
      output in_rd_en, dout, out_wr_en
   );
endinterface

// File: rtl/fir_decim.sv
// Decimating FIR low-pass: collects DECIMATION samples into a NUM_TAPS history,
// then runs one sequential multiply-accumulate pass and pushes a single result.
module fir_decim #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_TAPS   = 32,
   parameter int DECIMATION = 8,
   parameter int BITS       = 10,
   parameter logic signed [DATA_WIDTH-1:0] COEFFS [NUM_TAPS] =
      '{default: DATA_WIDTH'((2 ** BITS) / NUM_TAPS)}
) (
   input logic        clock,
   input logic        reset,
   fir_decim_if.slave bus
);
   localparam int PW = 2 * DATA_WIDTH;
   localparam int CW = $clog2(DECIMATION + 1);
   localparam int TW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

   typedef enum logic [1:0] {
      S_SHIFT = 2'd0,
      S_MAC   = 2'd1,
      S_OUT   = 2'd2
   } state_t;

   state_t                       state_r;
   state_t                       state_s;
   logic [CW-1:0]                cnt_r;
   logic [TW-1:0]                tap_r;
   logic signed [DATA_WIDTH-1:0] acc_r;
   logic signed [DATA_WIDTH-1:0] dout_r;
   logic signed [DATA_WIDTH-1:0] x_r [NUM_TAPS];

   logic                         pop_s;
   logic                         push_s;
   logic                         last_pop_s;
   logic                         last_tap_s;
   logic signed [PW-1:0]         product_s;
   logic [DATA_WIDTH-1:0]        term_s;
   logic signed [DATA_WIDTH-1:0] sum_s;

   // Handshakes are forced low while reset is held so nothing moves during reset.
   assign pop_s      = (state_r == S_SHIFT) && !bus.in_empty && !reset;
   assign push_s     = (state_r == S_OUT) && !bus.out_full && !reset;
   assign last_pop_s = pop_s && (cnt_r == CW'(DECIMATION - 1));
   assign last_tap_s = (tap_r == TW'(NUM_TAPS - 1));

   // Full-width signed product, floor shift, then keep the low word; acc wraps.
   assign product_s = PW'(COEFFS[tap_r]) * PW'(x_r[tap_r]);
   assign term_s    = DATA_WIDTH'(product_s >>> BITS);
   assign sum_s     = acc_r + term_s;

   assign bus.in_rd_en  = pop_s;
   assign bus.out_wr_en = push_s;
   assign bus.dout      = dout_r;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= S_SHIFT;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_SHIFT: begin
            if (last_pop_s) state_s = S_MAC;
            else            state_s = S_SHIFT;
         end
         S_MAC: begin
            if (last_tap_s) state_s = S_OUT;
            else            state_s = S_MAC;
         end
         S_OUT: begin
            if (push_s) state_s = S_SHIFT;
            else        state_s = S_OUT;
         end
         default: state_s = S_SHIFT;
      endcase
   end

   // History shift, sample/tap counters, accumulator and output register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_r  <= '0;
         tap_r  <= '0;
         acc_r  <= '0;
         dout_r <= '0;
         for (int k = 0; k < NUM_TAPS; k++) begin
            x_r[k] <= '0;
         end
      end else begin
         case (state_r)
            S_SHIFT: begin
               if (pop_s) begin
                  x_r[0] <= bus.din;
                  for (int k = 1; k < NUM_TAPS; k++) begin
                     x_r[k] <= x_r[k-1];
                  end
                  if (last_pop_s) begin
                     cnt_r <= '0;
                     acc_r <= '0;
                     tap_r <= '0;
                  end else begin
                     cnt_r <= cnt_r + CW'(1);
                  end
               end
            end
            S_MAC: begin
               acc_r <= sum_s;
               if (last_tap_s) begin
                  tap_r  <= '0;
                  dout_r <= sum_s;
               end else begin
                  tap_r <= tap_r + TW'(1);
               end
            end
            S_OUT: begin
               dout_r <= dout_r;
            end
            default: begin
               cnt_r <= '0;
               tap_r <= '0;
            end
         endcase
      end
   end
endmodule
